// File: rtl/word_board_if.sv
// Pad-side signals of the word_board: four data switches, two buttons, serial out.
// The board logic takes the slave view; a pad ring or bench drives the master view.
interface word_board_if;
  logic sw1;
  logic sw2;
  logic sw3;
  logic sw4;
  logic btn_write;
  logic btn_auto;
  logic out;

  modport master (
    output sw1, sw2, sw3, sw4, btn_write, btn_auto,
    input  out
  );

  modport slave (
    input  sw1, sw2, sw3, sw4, btn_write, btn_auto,
    output out
  );
endinterface

// File: rtl/word_board.sv
// Switch-entry nibble buffer: debounced write/auto buttons, 8-deep circular store,
// and a 10-bit UART-style serial transmitter (start, 4 data LSB first, 3 pad, 2 stop).
module word_board #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BIT_CYCLES      = 434,
  parameter int DEPTH           = 8
) (
  input  logic         sysclk,
  input  logic         rst_n,
  word_board_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BT_W  = $clog2(BIT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BIT_CYCLES - 1);
  localparam int B_WR = 0;
  localparam int B_AU = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAD,
    S_STOP
  } state_t;

  logic [3:0]      r_sw_s1;
  logic [3:0]      r_sw_s2;
  logic [1:0]      r_btn_s1;
  logic [1:0]      r_btn_s2;
  logic [1:0]      r_btn_db;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  logic [3:0]       r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_off;
  logic             r_auto;
  logic             r_pending;
  logic [3:0]       r_pend_nib;
  logic [3:0]       r_tx_nib;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BT_W-1:0] r_bit_cnt;
  logic [1:0]      r_bit_idx;
  logic            w_bit_end;
  logic            w_start;
  logic            w_out;

  logic [PTR_W-1:0] w_rd_addr;
  logic             w_off_wrap;

  // Synchronizers and per-button debounce; a press pulse fires on the accepted 0->1 flip only.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_btn_db <= '0;
      r_press  <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sw_s1  <= {bus.sw4, bus.sw3, bus.sw2, bus.sw1};
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= {bus.btn_auto, bus.btn_write};
      r_btn_s2 <= r_btn_s1;
      for (int b = 0; b < 2; b++) begin
        r_press[b] <= 1'b0;
        if (r_btn_s2[b] != r_btn_db[b]) begin
          if (r_db_cnt[b] == DB_LAST) begin
            r_btn_db[b] <= r_btn_s2[b];
            r_db_cnt[b] <= '0;
            r_press[b]  <= r_btn_s2[b];
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
          end
        end else begin
          r_db_cnt[b] <= '0;
        end
      end
    end
  end

  // Replay offset is relative to the oldest entry, so it stays valid while the window slides.
  assign w_rd_addr  = r_wr_ptr - r_count[PTR_W-1:0] + r_rd_off;
  assign w_off_wrap = (CNT_W'(r_rd_off) + CNT_W'(1)) >= r_count;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_rd_off   <= '0;
      r_auto     <= 1'b0;
      r_pending  <= 1'b0;
      r_pend_nib <= '0;
      r_tx_nib   <= '0;
    end else begin
      if (w_start) begin
        r_tx_nib <= r_auto ? r_buf[w_rd_addr] : r_pend_nib;
        if (r_auto) r_rd_off <= w_off_wrap ? '0 : r_rd_off + PTR_W'(1);
        else        r_pending <= 1'b0;
      end
      // Ordering matters: write after frame start so a new nibble re-arms pending,
      // and the auto toggle last so it wins over both.
      if (r_press[B_WR]) begin
        r_buf[r_wr_ptr] <= r_sw_s2;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        if (r_count != CNT_W'(DEPTH)) r_count <= r_count + CNT_W'(1);
        if (!r_auto) begin
          r_pending  <= 1'b1;
          r_pend_nib <= r_sw_s2;
        end
      end
      if (r_press[B_AU]) begin
        r_auto    <= ~r_auto;
        r_pending <= 1'b0;
        r_rd_off  <= '0;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_bit_end = (r_bit_cnt == BT_LAST);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else if (r_state == S_IDLE) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else if (w_bit_end) begin
      r_bit_cnt <= '0;
      r_bit_idx <= (w_state_nxt != r_state) ? 2'd0 : r_bit_idx + 2'd1;
    end else begin
      r_bit_cnt <= r_bit_cnt + BT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_out       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (r_pending || (r_auto && r_count != '0)) begin
          w_state_nxt = S_START;
          w_start     = 1'b1;
        end
      end
      S_START: begin
        w_out = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_out = r_tx_nib[r_bit_idx];
        if (w_bit_end && r_bit_idx == 2'd3) w_state_nxt = S_PAD;
      end
      S_PAD: begin
        w_out = 1'b0;
        if (w_bit_end && r_bit_idx == 2'd2) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_out = 1'b1;
        if (w_bit_end && r_bit_idx == 2'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.out = w_out;

endmodule

// File: tb/tb_word_board.sv
// Bench for word_board: frame-level reference model checked every cycle, plus
// directed scenarios with hand-derived frame and latency expectations.
module tb_word_board;
  localparam int DEB   = 20;
  localparam int BIT   = 10;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_board_if bus ();

  word_board #(
    .DEBOUNCE_CYCLES(DEB),
    .BIT_CYCLES     (BIT),
    .DEPTH          (DEPTH)
  ) dut (
    .sysclk(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int lows = 0;

  // Reference model: input sync/debounce, a queue of stored nibbles (oldest first),
  // and the transmitter as "busy with frame bits, t cycles in".
  logic [3:0] m_sw1, m_sw2;
  logic [1:0] m_b1, m_b2, m_db, m_pulse;
  int         m_run [2];
  int         mq [$];
  bit         m_auto, m_pend;
  logic [3:0] m_pnib, m_nib;
  int         m_k;
  bit         m_busy;
  int         m_t;
  logic [9:0] m_frame;
  logic       m_exp = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0; m_db = '0; m_pulse = '0;
      m_run[0] = 0; m_run[1] = 0;
      mq.delete();
      m_auto = 0; m_pend = 0; m_pnib = '0; m_k = 0; m_busy = 0; m_t = 0;
    end else begin
      if (m_busy) begin
        if (m_t == 10 * BIT - 1) m_busy = 0;
        else m_t++;
      end else if (m_pend || (m_auto && mq.size() > 0)) begin
        if (m_auto) begin
          m_nib = 4'(mq[m_k]);
          m_k = (m_k + 1) % mq.size();
        end else begin
          m_nib = m_pnib;
          m_pend = 0;
        end
        m_frame = {2'b11, 3'b000, m_nib, 1'b0};
        m_busy = 1; m_t = 0;
      end
      if (m_pulse[0]) begin
        mq.push_back(int'(m_sw2));
        if (mq.size() > DEPTH) void'(mq.pop_front());
        if (!m_auto) begin m_pend = 1; m_pnib = m_sw2; end
      end
      if (m_pulse[1]) begin m_auto = !m_auto; m_pend = 0; m_k = 0; end
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = 1'b0;
        if (m_b2[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_db[b] = m_b2[b]; m_run[b] = 0; m_pulse[b] = m_b2[b];
          end
        end else m_run[b] = 0;
      end
      m_sw2 = m_sw1;
      m_sw1 = {bus.sw4, bus.sw3, bus.sw2, bus.sw1};
      m_b2  = m_b1;
      m_b1  = {bus.btn_auto, bus.btn_write};
    end
    m_exp = m_busy ? m_frame[m_t / BIT] : 1'b1;
  end

  always @(posedge clk) begin
    #2;
    n_checks++;
    if (bus.out !== m_exp) begin
      n_errors++;
      $display("FAIL out_vs_model at %0t: out=%b expected=%b", $time, bus.out, m_exp);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.out === 1'b0) lows++;
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    {bus.sw4, bus.sw3, bus.sw2, bus.sw1} = v;
  endtask

  task automatic btn(input int which, input logic v);
    if (which == 0 || which == 2) bus.btn_write = v;
    if (which == 1 || which == 2) bus.btn_auto  = v;
  endtask

  task automatic wait_fall(output bit fell);
    int t;
    t = 0; fell = 0;
    while (t < 400 && !fell) begin
      @(negedge clk);
      t++;
      if (bus.out === 1'b0) fell = 1;
    end
    check("fall_seen", fell, 1);
  endtask

  // Called at the first low sample of a frame; samples each bit mid-way.
  task automatic sample_frame(output logic [9:0] b);
    repeat (BIT / 2) @(negedge clk);
    b[0] = bus.out;
    for (int i = 1; i < 10; i++) begin
      repeat (BIT) @(negedge clk);
      b[i] = bus.out;
    end
  endtask

  task automatic rx(output logic [3:0] nib);
    bit fell;
    logic [9:0] b;
    wait_fall(fell);
    nib = 4'bxxxx;
    if (fell) begin
      sample_frame(b);
      check("frame_shape", {b[9:5], b[0]}, 6'b110000);
      nib = b[4:1];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [9:0] fb;
  logic [3:0] nib;
  bit         fell;
  int         op, w;

  initial begin
    set_sw(4'h0);
    btn(2, 1'b0);
    rst_n = 1'b0;
    cyc(3);
    #1 check("rst_out", bus.out, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Nibble 8: out falls DEB+4 clocks after the raw press edge.
    set_sw(4'h8);
    cyc(4);
    btn(0, 1'b1);
    repeat (DEB + 3) @(negedge clk);
    check("lat_before", bus.out, 1);
    @(negedge clk);
    check("lat_fall", bus.out, 0);
    sample_frame(fb);
    check("frame_n8", fb, 10'h310);
    btn(0, 1'b0);
    cyc(DEB + 5);

    set_sw(4'h9);
    cyc(3);
    btn(0, 1'b1);
    wait_fall(fell);
    sample_frame(fb);
    check("frame_n9", fb, 10'h312);
    btn(0, 1'b0);
    cyc(DEB + 5);

    // Buffer {8,9} replayed in auto mode, then auto switched off.
    btn(1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rx(nib);
      check("auto_two", nib, (i % 2) ? 4'h9 : 4'h8);
    end
    btn(1, 1'b0);
    cyc(DEB + 5);
    btn(1, 1'b1);
    cyc(DEB + 3 + 11 * BIT);
    btn(1, 1'b0);
    lows = 0;
    cyc(30 * BIT);
    check("auto_off_idle", lows, 0);

    lows = 0;
    for (int i = 0; i < 30; i++) begin
      btn(0, 1'b1);
      cyc($urandom_range(1, DEB / 2));
      btn(0, 1'b0);
      cyc($urandom_range(1, DEB / 2));
    end
    cyc(25 * BIT);
    check("bounce_idle", lows, 0);

    // Two presses during one frame: frame of 3 intact, then only 6 follows.
    set_sw(4'h3);
    cyc(3);
    btn(0, 1'b1);
    wait_fall(fell);
    fork
      sample_frame(fb);
      begin
        btn(0, 1'b0);
        cyc(DEB + 3);
        set_sw(4'h5);
        btn(0, 1'b1);
        cyc(DEB + 3);
        btn(0, 1'b0);
        cyc(DEB + 3);
        set_sw(4'h6);
        btn(0, 1'b1);
        cyc(DEB + 3);
      end
    join
    check("dbl_first", fb, 10'h306);
    btn(0, 1'b0);
    rx(nib);
    check("dbl_second", nib, 4'h6);
    cyc(DEB + 5);
    lows = 0;
    cyc(30 * BIT);
    check("dbl_no_more", lows, 0);

    // Nine writes after a clean reset, then auto replays from entry 1.
    @(negedge clk);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int v = 1; v <= 9; v++) begin
      set_sw(4'(v));
      cyc(3);
      btn(0, 1'b1);
      rx(nib);
      check("wr_seq", nib, v);
      btn(0, 1'b0);
      cyc(DEB + 5);
    end
    btn(1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      rx(nib);
      check("auto_seq", nib, 2 + (i % 8));
    end
    btn(1, 1'b0);
    cyc(DEB + 5);
    btn(1, 1'b1);
    cyc(DEB + 3 + 11 * BIT);
    btn(1, 1'b0);
    lows = 0;
    cyc(30 * BIT);
    check("auto_stop", lows, 0);

    // Reset mid-frame, then auto with an empty buffer.
    set_sw(4'hA);
    cyc(3);
    btn(0, 1'b1);
    wait_fall(fell);
    cyc(3 * BIT);
    rst_n = 1'b0;
    btn(0, 1'b0);
    #1 check("rst_midframe", bus.out, 1);
    cyc(3);
    rst_n = 1'b1;
    btn(1, 1'b1);
    cyc(DEB + 5);
    btn(1, 1'b0);
    lows = 0;
    cyc(40 * BIT);
    check("auto_empty", lows, 0);

    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 1, 2: begin
          set_sw(4'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            repeat (3) begin
              btn(0, 1'b1); cyc($urandom_range(1, 5));
              btn(0, 1'b0); cyc($urandom_range(1, 5));
            end
          end
          btn(0, 1'b1);
          cyc($urandom_range(DEB + 2, 3 * DEB));
          btn(0, 1'b0);
        end
        3: begin
          btn(1, 1'b1);
          cyc($urandom_range(DEB + 2, 2 * DEB));
          btn(1, 1'b0);
        end
        4: begin
          set_sw(4'($urandom));
          cyc(3);
          btn(2, 1'b1);
          cyc($urandom_range(DEB + 2, 2 * DEB));
          btn(2, 1'b0);
        end
        5: begin
          w = ($urandom_range(0, 1) == 1) ? DEB - 1 : DEB;
          set_sw(4'($urandom));
          cyc(3);
          btn(0, 1'b1);
          cyc(w);
          btn(0, 1'b0);
        end
        default: begin
          repeat (4) begin
            set_sw(4'($urandom));
            cyc($urandom_range(1, 20));
          end
        end
      endcase
      cyc(DEB + 5 + $urandom_range(0, 12 * BIT));
    end

    btn(2, 1'b0);
    cyc(12 * BIT);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
